// File: rtl/calc_pkg.sv
// Shared types for the calculator command path: ALU opcodes, sequencer states
// and the default datapath width.
package calc_pkg;

  localparam int CALC_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    PRESENT
  } seq_state_e;

endpackage

// File: rtl/cycle_timer.sv
// Saturating cycle counter: o_expired is high once the count reaches TERMINAL-1.
module cycle_timer #(
  parameter int TERMINAL = 64,
  localparam int W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [W-1:0] LAST = W'(TERMINAL - 1);

  logic [W-1:0] count_q, count_d;

  assign o_expired = (count_q == LAST);

  // Holding at LAST keeps the expiry level stable instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (i_clear)
      count_d = '0;
    else if (i_enable && !o_expired)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command-side ALU partner: issues one operation at a time, collects the result
// (or a timeout) and presents it to the display path, keeping a chaining accumulator.
module alu_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH     = CALC_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_cmd_a,
  input  logic [DATA_WIDTH-1:0] i_cmd_b,
  input  logic [1:0]            i_cmd_op,
  input  logic                  i_cmd_signed,
  input  logic                  i_cmd_chain,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  output logic [DATA_WIDTH-1:0] o_alu_input_a,
  output logic [DATA_WIDTH-1:0] o_alu_input_b,
  output logic [1:0]            o_alu_input_op,
  output logic                  o_alu_input_signed,
  output logic                  o_alu_input_valid,
  input  logic                  i_alu_input_ready,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_alu_error,
  input  logic                  i_alu_result_valid,
  output logic                  o_alu_result_ready,
  output logic [DATA_WIDTH-1:0] o_res_data,
  output logic                  o_res_error,
  output logic                  o_res_timeout,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [DATA_WIDTH-1:0] o_acc
);

  seq_state_e            state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  alu_valid_q, alu_valid_d;
  logic                  alu_res_ready_q, alu_res_ready_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  alu_op_e               op_q, op_d;
  logic                  signed_q, signed_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_error_q, res_error_d;
  logic                  res_timeout_q, res_timeout_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  stale_q, stale_d;

  logic cmd_fire, alu_in_fire, alu_res_fire;
  logic timer_clear, timer_enable, timer_expired;

  assign cmd_fire     = i_cmd_valid && cmd_ready_q;
  assign alu_in_fire  = alu_valid_q && i_alu_input_ready;
  assign alu_res_fire = i_alu_result_valid && alu_res_ready_q;
  assign timer_clear  = (state_q == IDLE) && cmd_fire;
  assign timer_enable = (state_q == ISSUE) || (state_q == WAIT);

  cycle_timer #(.TERMINAL(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (timer_clear),
    .i_enable  (timer_enable),
    .o_expired (timer_expired)
  );

  // A handshake in the expiry cycle always wins over the timeout branch.
  always_comb begin
    state_d         = state_q;
    cmd_ready_d     = cmd_ready_q;
    alu_valid_d     = alu_valid_q;
    alu_res_ready_d = 1'b1;
    op_a_d          = op_a_q;
    op_b_d          = op_b_q;
    op_d            = op_q;
    signed_d        = signed_q;
    res_valid_d     = res_valid_q;
    res_data_d      = res_data_q;
    res_error_d     = res_error_q;
    res_timeout_d   = res_timeout_q;
    acc_d           = acc_q;
    stale_d         = stale_q;

    if (alu_res_fire && stale_q)
      stale_d = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_fire) begin
          op_a_d      = i_cmd_chain ? acc_q : i_cmd_a;
          op_b_d      = i_cmd_b;
          op_d        = alu_op_e'(i_cmd_op);
          signed_d    = i_cmd_signed;
          cmd_ready_d = 1'b0;
          alu_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (alu_in_fire) begin
          alu_valid_d = 1'b0;
          state_d     = WAIT;
        end else if (timer_expired) begin
          alu_valid_d   = 1'b0;
          res_valid_d   = 1'b1;
          res_data_d    = '0;
          res_error_d   = 1'b1;
          res_timeout_d = 1'b1;
          state_d       = PRESENT;
        end
      end
      WAIT: begin
        if (alu_res_fire && !stale_q) begin
          res_valid_d   = 1'b1;
          res_data_d    = i_alu_result;
          res_error_d   = i_alu_error;
          res_timeout_d = 1'b0;
          if (!i_alu_error)
            acc_d = i_alu_result;
          state_d = PRESENT;
        end else if (timer_expired) begin
          res_valid_d   = 1'b1;
          res_data_d    = '0;
          res_error_d   = 1'b1;
          res_timeout_d = 1'b1;
          stale_d       = 1'b1;
          state_d       = PRESENT;
        end
      end
      PRESENT: begin
        if (i_res_ready) begin
          res_valid_d   = 1'b0;
          res_data_d    = '0;
          res_error_d   = 1'b0;
          res_timeout_d = 1'b0;
          cmd_ready_d   = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cmd_ready_q     <= 1'b0;
      alu_valid_q     <= 1'b0;
      alu_res_ready_q <= 1'b0;
      op_a_q          <= '0;
      op_b_q          <= '0;
      op_q            <= ADD;
      signed_q        <= 1'b0;
      res_valid_q     <= 1'b0;
      res_data_q      <= '0;
      res_error_q     <= 1'b0;
      res_timeout_q   <= 1'b0;
      acc_q           <= '0;
      stale_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cmd_ready_q     <= cmd_ready_d;
      alu_valid_q     <= alu_valid_d;
      alu_res_ready_q <= alu_res_ready_d;
      op_a_q          <= op_a_d;
      op_b_q          <= op_b_d;
      op_q            <= op_d;
      signed_q        <= signed_d;
      res_valid_q     <= res_valid_d;
      res_data_q      <= res_data_d;
      res_error_q     <= res_error_d;
      res_timeout_q   <= res_timeout_d;
      acc_q           <= acc_d;
      stale_q         <= stale_d;
    end
  end

  assign o_cmd_ready        = cmd_ready_q;
  assign o_alu_input_a      = op_a_q;
  assign o_alu_input_b      = op_b_q;
  assign o_alu_input_op     = op_q;
  assign o_alu_input_signed = signed_q;
  assign o_alu_input_valid  = alu_valid_q;
  assign o_alu_result_ready = alu_res_ready_q;
  assign o_res_data         = res_data_q;
  assign o_res_error        = res_error_q;
  assign o_res_timeout      = res_timeout_q;
  assign o_res_valid        = res_valid_q;
  assign o_acc              = acc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer: the bench plays front-end, ALU and display,
// and predicts every presented result from a transaction-level model.
module tb_alu_sequencer;

  localparam int DW = 16;
  localparam int TC = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] i_cmd_a = '0, i_cmd_b = '0;
  logic [1:0]    i_cmd_op = '0;
  logic          i_cmd_signed = 1'b0, i_cmd_chain = 1'b0, i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic [DW-1:0] o_alu_input_a, o_alu_input_b;
  logic [1:0]    o_alu_input_op;
  logic          o_alu_input_signed, o_alu_input_valid;
  logic          i_alu_input_ready = 1'b0;
  logic [DW-1:0] i_alu_result = '0;
  logic          i_alu_error = 1'b0, i_alu_result_valid = 1'b0;
  logic          o_alu_result_ready;
  logic [DW-1:0] o_res_data;
  logic          o_res_error, o_res_timeout, o_res_valid;
  logic          i_res_ready = 1'b0;
  logic [DW-1:0] o_acc;

  alu_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b), .i_cmd_op(i_cmd_op),
    .i_cmd_signed(i_cmd_signed), .i_cmd_chain(i_cmd_chain),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .o_alu_input_a(o_alu_input_a), .o_alu_input_b(o_alu_input_b),
    .o_alu_input_op(o_alu_input_op), .o_alu_input_signed(o_alu_input_signed),
    .o_alu_input_valid(o_alu_input_valid), .i_alu_input_ready(i_alu_input_ready),
    .i_alu_result(i_alu_result), .i_alu_error(i_alu_error),
    .i_alu_result_valid(i_alu_result_valid), .o_alu_result_ready(o_alu_result_ready),
    .o_res_data(o_res_data), .o_res_error(o_res_error), .o_res_timeout(o_res_timeout),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_acc(o_acc)
  );

  always #5 clk = ~clk;

  int            compares = 0;
  int            errors   = 0;
  logic [DW-1:0] model_acc   = '0;
  logic          model_stale = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compares++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Behavioural ALU: {error, data}; division by zero is the only error.
  function automatic logic [DW:0] refAlu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [1:0] op, input logic sgn);
    int sa, sb;
    sa = sgn ? int'($signed(a)) : int'(a);
    sb = sgn ? int'($signed(b)) : int'(b);
    case (op)
      2'd0:    return {1'b0, 16'(sa + sb)};
      2'd1:    return {1'b0, 16'(sa - sb)};
      2'd2:    return {1'b0, 16'(sa * sb)};
      default: begin
        if (sb == 0) return {1'b1, 16'h0000};
        return {1'b0, 16'(sa / sb)};
      end
    endcase
  endfunction

  // One-cycle result pulse while the sequencer is not waiting on the ALU.
  task automatic idlePulse(input logic [DW-1:0] value);
    i_alu_result       = value;
    i_alu_error        = 1'b0;
    i_alu_result_valid = 1'b1;
    @(negedge clk);
    i_alu_result_valid = 1'b0;
    model_stale        = 1'b0;
  endtask

  // Full command transaction: in_delay = ALU input-ready delay, res_delay = cycles in
  // WAIT before the result, late_in_wait = deliver a pending late result inside WAIT.
  task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [1:0] op, input logic sgn, input logic chain,
                               input int in_delay, input int res_delay,
                               input logic late_in_wait, input int res_hold);
    logic [DW-1:0] exp_a, exp_data;
    logic [DW:0]   ref_res;
    logic          exp_err, exp_to, late_pending, ok, issue_to, in_hs, first;
    int            r, cyc, wait_cyc, valid_cycles, n;

    n = 0;
    while (!o_cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_ready", o_cmd_ready, 1);
    if (model_stale && !late_in_wait) idlePulse(16'd99);

    exp_a        = chain ? model_acc : a;
    ref_res      = refAlu(exp_a, b, op, sgn);
    late_pending = model_stale && late_in_wait;
    r            = (late_pending && res_delay < 1) ? 1 : res_delay;
    issue_to     = (in_delay >= TC);
    ok           = !issue_to && (in_delay + 1 + r <= TC - 1);

    i_cmd_a = a; i_cmd_b = b; i_cmd_op = op; i_cmd_signed = sgn; i_cmd_chain = chain;
    i_cmd_valid = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_cmd_a = ~a; i_cmd_b = ~b;

    cyc = 1; in_hs = 0; wait_cyc = 0; valid_cycles = 0; first = 1;
    while (!o_res_valid && cyc <= TC + 4) begin
      i_alu_result_valid = 1'b0;
      if (!in_hs) begin
        i_alu_input_ready = (cyc - 1 >= in_delay);
        if (o_alu_input_valid) begin
          valid_cycles++;
          if (first) begin
            checkOutput("alu_a", o_alu_input_a, exp_a);
            checkOutput("alu_b", o_alu_input_b, b);
            checkOutput("alu_op", o_alu_input_op, op);
            checkOutput("alu_signed", o_alu_input_signed, sgn);
          end
          first = 0;
          if (i_alu_input_ready) in_hs = 1;
        end
      end else begin
        i_alu_input_ready = 1'b0;
        if (late_pending && wait_cyc == 0) begin
          i_alu_result = 16'd99; i_alu_error = 1'b0; i_alu_result_valid = 1'b1;
          model_stale  = 1'b0;
        end else if (wait_cyc == r) begin
          i_alu_result = ref_res[DW-1:0]; i_alu_error = ref_res[DW];
          i_alu_result_valid = 1'b1;
        end
        wait_cyc++;
      end
      @(negedge clk);
      cyc++;
    end
    i_alu_result_valid = 1'b0;
    i_alu_input_ready  = 1'b0;

    checkOutput("present_reached", o_res_valid, 1);
    checkOutput("latency", cyc, ok ? in_delay + r + 3 : TC + 1);
    checkOutput("issue_valid_cycles", valid_cycles, issue_to ? TC : in_delay + 1);

    exp_data = ok ? ref_res[DW-1:0] : '0;
    exp_err  = ok ? ref_res[DW] : 1'b1;
    exp_to   = !ok;
    if (ok && !ref_res[DW]) model_acc = ref_res[DW-1:0];
    if (!ok && !issue_to) model_stale = 1'b1;

    for (int h = 0; h <= res_hold; h++) begin
      i_res_ready = (h == res_hold);
      checkOutput("res_valid", o_res_valid, 1);
      checkOutput("res_data", o_res_data, exp_data);
      checkOutput("res_error", o_res_error, exp_err);
      checkOutput("res_timeout", o_res_timeout, exp_to);
      @(negedge clk);
    end
    i_res_ready = 1'b0;
    checkOutput("res_valid_drop", o_res_valid, 0);
    checkOutput("acc", o_acc, model_acc);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] ra, rb;
    int            sel;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_cmd_ready", o_cmd_ready, 0);
    checkOutput("rst_alu_valid", o_alu_input_valid, 0);
    checkOutput("rst_res_valid", o_res_valid, 0);
    checkOutput("rst_alu_res_ready", o_alu_result_ready, 0);
    checkOutput("rst_acc", o_acc, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_cmd_ready", o_cmd_ready, 1);
    checkOutput("post_rst_alu_res_ready", o_alu_result_ready, 1);

    // Basic ADD, then chained MUL, then divide by zero
    applyStimulus(16'd7, 16'd5, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    checkOutput("ready_cycle4", o_cmd_ready, 1);
    checkOutput("acc_after_add", o_acc, 12);
    applyStimulus(16'd0, 16'd3, 2'd2, 1'b0, 1'b1, 0, 0, 1'b0, 0);
    checkOutput("acc_after_chain", o_acc, 36);
    applyStimulus(16'd10, 16'd0, 2'd3, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    checkOutput("acc_after_div0", o_acc, 36);

    // ALU never answers: WAIT timeout, then the late result is discarded
    applyStimulus(16'd1, 16'd2, 2'd0, 1'b0, 1'b0, 0, 20, 1'b0, 0);
    applyStimulus(16'd4, 16'd5, 2'd0, 1'b0, 1'b0, 0, 0, 1'b1, 0);
    checkOutput("acc_after_late", o_acc, 9);

    // ALU input never ready: ISSUE abort, no stale; stray result in IDLE ignored
    applyStimulus(16'd20, 16'd6, 2'd1, 1'b1, 1'b0, 20, 0, 1'b0, 0);
    idlePulse(16'hDEAD);
    applyStimulus(16'hFFF0, 16'd3, 2'd3, 1'b1, 1'b0, 0, 0, 1'b0, 5);

    // Boundaries: handshake in the expiry cycle, one cycle too late
    applyStimulus(16'd100, 16'd23, 2'd0, 1'b0, 1'b0, 3, 3, 1'b0, 0);
    applyStimulus(16'd100, 16'd23, 2'd1, 1'b0, 1'b0, 3, 4, 1'b0, 1);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
      applyStimulus(ra, rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    (sel == 0) ? 20 : $urandom_range(0, 3),
                    (sel == 1) ? 20 : $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // Async reset while waiting on the ALU
    if (model_stale) idlePulse(16'd99);
    applyStimulus(16'd7, 16'd5, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    i_cmd_a = 16'd1; i_cmd_b = 16'd2; i_cmd_op = 2'd0; i_cmd_chain = 1'b0;
    i_cmd_valid = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_alu_input_ready = 1'b1;
    @(negedge clk);
    i_alu_input_ready = 1'b0;
    checkOutput("wait_acc_before_rst", o_acc, 12);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_cmd_ready", o_cmd_ready, 0);
    checkOutput("async_alu_valid", o_alu_input_valid, 0);
    checkOutput("async_alu_a", o_alu_input_a, 0);
    checkOutput("async_alu_b", o_alu_input_b, 0);
    checkOutput("async_res_valid", o_res_valid, 0);
    checkOutput("async_res_data", o_res_data, 0);
    checkOutput("async_alu_res_ready", o_alu_result_ready, 0);
    checkOutput("async_acc", o_acc, 0);
    model_acc   = '0;
    model_stale = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(16'd0, 16'd9, 2'd0, 1'b0, 1'b1, 0, 1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
